systolic_row_deskew: RTL and testbench

- Sits at the output edge of the systolic matrix multiplier array.
- Each column's results leave the array skewed: column j's value for a given row arrives j shift steps after column 0's.
- The block delays each column by the complementary number of shift steps so that all columns of a row line up. It then buffers aligned rows in a small FIFO and presents them on a valid/ready interface.
- It undoes the input skewing applied by the array's feed-side delay lines.

---
 rtl/systolic_row_deskew_if.sv | 25 ++
 rtl/systolic_row_deskew.sv | 88 ++++++++
 tb/tb_systolic_row_deskew.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/systolic_row_deskew_if.sv
// systolic_row_deskew_if: skewed-column input, aligned-row FIFO output and status bundle
interface systolic_row_deskew_if #(
    parameter int ACC_WIDTH = 16,
    parameter int COLS = 4,
    parameter int DEPTH = 4
);
    logic                           clear_i;
    logic                           shift;
    logic                           valid_i;
    logic [COLS*ACC_WIDTH-1:0]      data_i;
    logic                           ready_o;
    logic                           out_valid;
    logic                           out_ready;
    logic [COLS*ACC_WIDTH-1:0]      out_data;
    logic [$clog2(DEPTH+1)-1:0]     level_o;
    logic                           overflow_o;
    modport slave (
        input  clear_i, shift, valid_i, data_i, out_ready,
        output ready_o, out_valid, out_data, level_o, overflow_o
    );
    modport master (
        output clear_i, shift, valid_i, data_i, out_ready,
        input  ready_o, out_valid, out_data, level_o, overflow_o
    );
endinterface

// File: rtl/systolic_row_deskew.sv
// systolic_row_deskew: delays each skewed array column by its complement so rows line up,
// then queues aligned rows in a DEPTH-entry FIFO behind a valid/ready interface.
module systolic_row_deskew #(
    parameter int ACC_WIDTH = 16,
    parameter int COLS = 4,
    parameter int DEPTH = 4
) (
    input logic clk,
    input logic reset,
    systolic_row_deskew_if.slave bus
);
    localparam int RW = COLS * ACC_WIDTH;
    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
    localparam logic [LW-1:0] FULL = LW'(DEPTH);
    logic          flush;
    logic [RW-1:0] row;
    logic          row_valid;
    assign flush = reset || bus.clear_i;
    genvar j;
    generate
        for (j = 0; j < COLS - 1; j++) begin : g_col
            localparam int L = COLS - 1 - j;
            logic [ACC_WIDTH-1:0] line_q [L];
            always_ff @(posedge clk) begin
                if (flush) begin
                    for (int s = 0; s < L; s++) line_q[s] <= '0;
                end else if (bus.shift) begin
                    line_q[0] <= bus.data_i[j*ACC_WIDTH +: ACC_WIDTH];
                    for (int s = 1; s < L; s++) line_q[s] <= line_q[s-1];
                end
            end
            assign row[j*ACC_WIDTH +: ACC_WIDTH] = line_q[L-1];
        end
        if (COLS > 1) begin : g_vl
            logic [COLS-2:0] vl_q;
            always_ff @(posedge clk) begin
                if (flush) begin
                    vl_q <= '0;
                end else if (bus.shift) begin
                    vl_q[0] <= bus.valid_i;
                    for (int s = 1; s < COLS - 1; s++) vl_q[s] <= vl_q[s-1];
                end
            end
            assign row_valid = vl_q[COLS-2];
        end else begin : g_nvl
            assign row_valid = bus.valid_i;
        end
    endgenerate
    // The last column arrives already aligned and bypasses any storage.
    assign row[(COLS-1)*ACC_WIDTH +: ACC_WIDTH] = bus.data_i[(COLS-1)*ACC_WIDTH +: ACC_WIDTH];
    logic [RW-1:0] mem_q [DEPTH];
    logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [LW-1:0] lvl_q, lvl_d;
    logic          ovf_q, ovf_d;
    logic          full, pop, try_push, push;
    always_comb begin
        full     = lvl_q == FULL;
        pop      = (lvl_q != '0) && bus.out_ready;
        try_push = bus.shift && row_valid;
        push     = try_push && (!full || pop);
        rd_d     = pop ? (rd_q == LAST ? '0 : rd_q + 1'b1) : rd_q;
        wr_d     = push ? (wr_q == LAST ? '0 : wr_q + 1'b1) : wr_q;
        lvl_d    = lvl_q + LW'(push) - LW'(pop);
        ovf_d    = ovf_q || (try_push && !push);
    end
    always_ff @(posedge clk) begin
        if (flush) begin
            for (int d = 0; d < DEPTH; d++) mem_q[d] <= '0;
            rd_q  <= '0;
            wr_q  <= '0;
            lvl_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            if (push) mem_q[wr_q] <= row;
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            lvl_q <= lvl_d;
            ovf_q <= ovf_d;
        end
    end
    assign bus.out_valid  = lvl_q != '0;
    assign bus.out_data   = mem_q[rd_q];
    assign bus.level_o    = lvl_q;
    assign bus.ready_o    = !full;
    assign bus.overflow_o = ovf_q;
endmodule

// File: tb/tb_systolic_row_deskew.sv
// tb_systolic_row_deskew: table vectors, directed corner sequences and a random run against a row-history model
module tb_systolic_row_deskew;
    localparam int W = 16;
    localparam int C = 4;
    localparam int D = 4;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;
    systolic_row_deskew_if #(.ACC_WIDTH(W), .COLS(C), .DEPTH(D)) bus();
    systolic_row_deskew #(.ACC_WIDTH(W), .COLS(C), .DEPTH(D)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );
    typedef struct {
        logic        sh;
        logic        vi;
        logic        ord;
        logic [63:0] d;
        logic        ev;
        logic [2:0]  el;
        logic [63:0] ed;
    } vec_t;
    vec_t tbl[5];
    int checks = 0;
    int errors = 0;
    logic [63:0] q[$];
    logic [63:0] hd[$];
    bit hv[$];
    bit m_ovf = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, act, exp);
        end
    endtask

    // Model: row r's column j is the column-j value sampled on the (r_start+j)-th shift since flush.
    task automatic cyc();
        logic [63:0] r, t;
        bit pop, full, do_push;
        int n;
        if (reset || bus.clear_i) begin
            q.delete();
            hd.delete();
            hv.delete();
            m_ovf = 1'b0;
        end else begin
            full = q.size() == D;
            pop = q.size() != 0 && bus.out_ready;
            do_push = 1'b0;
            r = '0;
            if (bus.shift) begin
                hd.push_back(bus.data_i);
                hv.push_back(bus.valid_i);
                n = hd.size() - 1;
                if (n >= C - 1 && hv[n-C+1]) begin
                    for (int j = 0; j < C; j++) begin
                        t = hd[n-C+1+j];
                        r[j*W +: W] = t[j*W +: W];
                    end
                    if (full && !pop) m_ovf = 1'b1;
                    else do_push = 1'b1;
                end
            end
            if (pop) void'(q.pop_front());
            if (do_push) q.push_back(r);
        end
        @(posedge clk);
        #1;
        chk("out_valid", 64'(bus.out_valid), 64'(q.size() != 0));
        chk("level_o", 64'(bus.level_o), 64'(q.size()));
        chk("ready_o", 64'(bus.ready_o), 64'(q.size() != D));
        chk("overflow_o", 64'(bus.overflow_o), 64'(m_ovf));
        if (q.size() != 0) chk("out_data", bus.out_data, q[0]);
    endtask

    task automatic drive(input logic sh, input logic vi, input logic [63:0] d, input logic ord);
        bus.shift = sh;
        bus.valid_i = vi;
        bus.data_i = d;
        bus.out_ready = ord;
    endtask

    task automatic skew(input int n, input int base, input bit rdy_last);
        logic [63:0] d;
        int r;
        for (int k = 0; k < n + C - 1; k++) begin
            d = '0;
            for (int j = 0; j < C; j++) begin
                r = k - j;
                if (r >= 0 && r < n) d[j*W +: W] = W'(base + r + j * 256);
            end
            drive(1'b1, k < n, d, (k == n + C - 2) ? rdy_last : 1'b0);
            cyc();
        end
        drive(1'b0, 1'b0, '0, 1'b0);
    endtask

    task automatic drain(input int n, input int base, input string nm);
        bus.out_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            chk(nm, 64'(bus.out_data[W-1:0]), 64'(base + i));
            cyc();
        end
        bus.out_ready = 1'b0;
        chk({nm, "_empty"}, 64'(bus.out_valid), 64'd0);
    endtask

    initial begin
        tbl[0] = '{1'b1, 1'b1, 1'b0, 64'h0000_0000_0000_0011, 1'b0, 3'd0, 64'h0};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 64'h0000_0000_0022_0000, 1'b0, 3'd0, 64'h0};
        tbl[2] = '{1'b1, 1'b0, 1'b0, 64'h0000_0033_0000_0000, 1'b0, 3'd0, 64'h0};
        tbl[3] = '{1'b1, 1'b0, 1'b0, 64'h0044_0000_0000_0000, 1'b1, 3'd1, 64'h0044_0033_0022_0011};
        tbl[4] = '{1'b0, 1'b0, 1'b1, 64'h0, 1'b0, 3'd0, 64'h0};
        bus.clear_i = 1'b0;
        drive(1'b1, 1'b1, 64'h1234_5678_9abc_def0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            cyc();
            chk("rst_out_data", bus.out_data, 64'h0);
        end
        reset = 1'b0;
        drive(1'b0, 1'b0, '0, 1'b0);
        cyc();
        chk("rst_rel_out_data", bus.out_data, 64'h0);
        for (int i = 0; i < 5; i++) begin
            drive(tbl[i].sh, tbl[i].vi, tbl[i].d, tbl[i].ord);
            cyc();
            chk("tbl_valid", 64'(bus.out_valid), 64'(tbl[i].ev));
            chk("tbl_level", 64'(bus.level_o), 64'(tbl[i].el));
            if (tbl[i].ev) chk("tbl_data", bus.out_data, tbl[i].ed);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, i == 0, tbl[i].d, 1'b0);
            cyc();
            chk("gap_valid_shift", 64'(bus.out_valid), 64'(i == 3));
            if (i == 3) chk("gap_data", bus.out_data, 64'h0044_0033_0022_0011);
            if (i < 3) begin
                drive(1'b0, 1'b0, 64'hffff_ffff_ffff_ffff, 1'b0);
                for (int g = 0; g < 3; g++) begin
                    cyc();
                    chk("gap_valid_idle", 64'(bus.out_valid), 64'd0);
                end
            end
        end
        drive(1'b0, 1'b0, '0, 1'b0);
        cyc();
        chk("gap_level", 64'(bus.level_o), 64'd1);
        drain(1, 16'h0011, "gap_pop");
        skew(5, 1, 1'b0);
        chk("bp_ready", 64'(bus.ready_o), 64'd0);
        chk("bp_level", 64'(bus.level_o), 64'd4);
        chk("bp_overflow", 64'(bus.overflow_o), 64'd1);
        drain(4, 1, "bp_order");
        chk("bp_overflow_sticky", 64'(bus.overflow_o), 64'd1);
        bus.clear_i = 1'b1;
        cyc();
        bus.clear_i = 1'b0;
        chk("clr_overflow", 64'(bus.overflow_o), 64'd0);
        skew(5, 16'h0010, 1'b1);
        chk("fp_level", 64'(bus.level_o), 64'd4);
        chk("fp_overflow", 64'(bus.overflow_o), 64'd0);
        drain(4, 16'h0011, "fp_order");
        drive(1'b1, 1'b1, 64'h0000_0000_0000_00aa, 1'b0);
        cyc();
        drive(1'b1, 1'b0, 64'h0000_0000_00bb_0000, 1'b0);
        cyc();
        drive(1'b0, 1'b0, '0, 1'b0);
        bus.clear_i = 1'b1;
        cyc();
        bus.clear_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 1'b0, (i == 0) ? 64'h0000_00cc_0000_0000 : (i == 1) ? 64'h00dd_0000_0000_0000 : 64'h0, 1'b0);
            cyc();
            chk("mc_valid", 64'(bus.out_valid), 64'd0);
            chk("mc_level", 64'(bus.level_o), 64'd0);
        end
        skew(1, 16'h0020, 1'b0);
        chk("mc_next_valid", 64'(bus.out_valid), 64'd1);
        chk("mc_next_data", bus.out_data, 64'h0320_0220_0120_0020);
        drain(1, 16'h0020, "mc_pop");
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, {$urandom, $urandom}, $urandom_range(0, 2) == 0);
            bus.clear_i = $urandom_range(0, 99) == 0;
            reset = $urandom_range(0, 499) == 0;
            cyc();
        end
        reset = 1'b0;
        bus.clear_i = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
